// File: rtl/debug_snapshot_uart_tx.sv
// Freezes debug_1..3 on start and streams them as a 14-byte 8N1 frame:
// sync byte, three words MSB byte first, then the XOR checksum of the 12 payload bytes.
module debug_snapshot_uart_tx #(
  parameter int unsigned BAUD_DIV  = 868,
  parameter logic [7:0]  SYNC_BYTE = 8'hA5
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start_i,
  input  logic [31:0] debug_1_i,
  input  logic [31:0] debug_2_i,
  input  logic [31:0] debug_3_i,
  output logic        tx_o,
  output logic        busy_o,
  output logic        done_o,
  output logic [15:0] frame_cnt_o
);

  localparam logic [1:0]  ST_IDLE   = 2'd0;
  localparam logic [1:0]  ST_START  = 2'd1;
  localparam logic [1:0]  ST_DATA   = 2'd2;
  localparam logic [1:0]  ST_STOP   = 2'd3;
  localparam logic [15:0] BAUD_LAST = 16'(BAUD_DIV - 1);
  localparam logic [3:0]  LAST_BYTE = 4'd13;

  logic [1:0]  state_q, state_d;
  logic [15:0] baud_cnt_q, baud_cnt_d;
  logic [2:0]  bit_cnt_q, bit_cnt_d;
  logic [3:0]  byte_idx_q, byte_idx_d;
  logic [31:0] snap_1_q, snap_1_d, snap_2_q, snap_2_d, snap_3_q, snap_3_d;
  logic        tx_q, tx_d;
  logic        done_q, done_d;
  logic [15:0] frame_cnt_q, frame_cnt_d;

  logic [31:0] word_xor;
  logic [7:0]  checksum;
  logic [7:0]  cur_byte;
  logic [2:0]  bit_nxt;
  logic        baud_end;

  // Byte-wise XOR of the three words equals the XOR of all 12 payload bytes.
  assign word_xor = snap_1_q ^ snap_2_q ^ snap_3_q;
  assign checksum = word_xor[31:24] ^ word_xor[23:16] ^ word_xor[15:8] ^ word_xor[7:0];
  assign bit_nxt  = bit_cnt_q + 3'd1;
  assign baud_end = (baud_cnt_q == BAUD_LAST);

  always_comb begin
    cur_byte = checksum;
    case (byte_idx_q)
      4'd0:    cur_byte = SYNC_BYTE;
      4'd1:    cur_byte = snap_1_q[31:24];
      4'd2:    cur_byte = snap_1_q[23:16];
      4'd3:    cur_byte = snap_1_q[15:8];
      4'd4:    cur_byte = snap_1_q[7:0];
      4'd5:    cur_byte = snap_2_q[31:24];
      4'd6:    cur_byte = snap_2_q[23:16];
      4'd7:    cur_byte = snap_2_q[15:8];
      4'd8:    cur_byte = snap_2_q[7:0];
      4'd9:    cur_byte = snap_3_q[31:24];
      4'd10:   cur_byte = snap_3_q[23:16];
      4'd11:   cur_byte = snap_3_q[15:8];
      4'd12:   cur_byte = snap_3_q[7:0];
      default: cur_byte = checksum;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    baud_cnt_d  = baud_cnt_q;
    bit_cnt_d   = bit_cnt_q;
    byte_idx_d  = byte_idx_q;
    snap_1_d    = snap_1_q;
    snap_2_d    = snap_2_q;
    snap_3_d    = snap_3_q;
    tx_d        = tx_q;
    done_d      = 1'b0;
    frame_cnt_d = frame_cnt_q;
    case (state_q)
      ST_IDLE: begin
        tx_d = 1'b1;
        if (start_i) begin
          snap_1_d   = debug_1_i;
          snap_2_d   = debug_2_i;
          snap_3_d   = debug_3_i;
          baud_cnt_d = 16'd0;
          bit_cnt_d  = 3'd0;
          byte_idx_d = 4'd0;
          tx_d       = 1'b0;
          state_d    = ST_START;
        end
      end
      ST_START: begin
        if (baud_end) begin
          baud_cnt_d = 16'd0;
          tx_d       = cur_byte[0];
          state_d    = ST_DATA;
        end else begin
          baud_cnt_d = baud_cnt_q + 16'd1;
        end
      end
      ST_DATA: begin
        if (baud_end) begin
          baud_cnt_d = 16'd0;
          if (bit_cnt_q == 3'd7) begin
            tx_d    = 1'b1;
            state_d = ST_STOP;
          end else begin
            bit_cnt_d = bit_nxt;
            tx_d      = cur_byte[bit_nxt];
          end
        end else begin
          baud_cnt_d = baud_cnt_q + 16'd1;
        end
      end
      default: begin
        if (baud_end) begin
          baud_cnt_d = 16'd0;
          bit_cnt_d  = 3'd0;
          if (byte_idx_q == LAST_BYTE) begin
            tx_d        = 1'b1;
            done_d      = 1'b1;
            frame_cnt_d = frame_cnt_q + 16'd1;
            state_d     = ST_IDLE;
          end else begin
            byte_idx_d = byte_idx_q + 4'd1;
            tx_d       = 1'b0;
            state_d    = ST_START;
          end
        end else begin
          baud_cnt_d = baud_cnt_q + 16'd1;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      baud_cnt_q  <= 16'd0;
      bit_cnt_q   <= 3'd0;
      byte_idx_q  <= 4'd0;
      snap_1_q    <= 32'd0;
      snap_2_q    <= 32'd0;
      snap_3_q    <= 32'd0;
      tx_q        <= 1'b1;
      done_q      <= 1'b0;
      frame_cnt_q <= 16'd0;
    end else begin
      state_q     <= state_d;
      baud_cnt_q  <= baud_cnt_d;
      bit_cnt_q   <= bit_cnt_d;
      byte_idx_q  <= byte_idx_d;
      snap_1_q    <= snap_1_d;
      snap_2_q    <= snap_2_d;
      snap_3_q    <= snap_3_d;
      tx_q        <= tx_d;
      done_q      <= done_d;
      frame_cnt_q <= frame_cnt_d;
    end
  end

  assign tx_o        = tx_q;
  assign busy_o      = (state_q != ST_IDLE);
  assign done_o      = done_q;
  assign frame_cnt_o = frame_cnt_q;

endmodule

// File: tb/tb_debug_snapshot_uart_tx.sv
// Directed bench: one instance at BAUD_DIV=4 and one at BAUD_DIV=2, frames decoded from tx_o.
module tb_debug_snapshot_uart_tx;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start4 = 1'b0, start2 = 1'b0;
  logic [31:0] d1 = '0, d2 = '0, d3 = '0;
  logic        tx4, busy4, done4, tx2, busy2, done2;
  logic [15:0] cnt4, cnt2;

  int errors = 0;
  int checks = 0;

  logic       wtx   [0:1023];
  logic       wdone [0:1023];
  logic [7:0] rx_bytes [0:13];
  int         width_err, frame_err;

  logic [7:0] gold [0:13] = '{8'hA5, 8'h00, 8'h00, 8'h00, 8'h0C, 8'h00, 8'h00, 8'h00,
                              8'hFF, 8'h00, 8'hB8, 8'hA3, 8'h98, 8'h70};
  logic [7:0] pat2 [0:13] = '{8'hA5, 8'h12, 8'h34, 8'h56, 8'h78, 8'hDE, 8'hAD, 8'hBE,
                              8'hEF, 8'h00, 8'h00, 8'h00, 8'h01, 8'h2B};

  always #5 clk = ~clk;

  debug_snapshot_uart_tx #(.BAUD_DIV(4), .SYNC_BYTE(8'hA5)) dut4 (
    .clk(clk), .rst_n(rst_n), .start_i(start4),
    .debug_1_i(d1), .debug_2_i(d2), .debug_3_i(d3),
    .tx_o(tx4), .busy_o(busy4), .done_o(done4), .frame_cnt_o(cnt4)
  );

  debug_snapshot_uart_tx #(.BAUD_DIV(2), .SYNC_BYTE(8'hA5)) dut2 (
    .clk(clk), .rst_n(rst_n), .start_i(start2),
    .debug_1_i(d1), .debug_2_i(d2), .debug_3_i(d3),
    .tx_o(tx2), .busy_o(busy2), .done_o(done2), .frame_cnt_o(cnt2)
  );

  // Samples n=0 (first start bit) through n=140*div (expected done cycle), one per negedge.
  task automatic record(input bit which, input int div, output int ndone);
    ndone = 0;
    for (int n = 0; n <= 140 * div; n++) begin
      if (n > 0) @(negedge clk);
      wtx[n]   = which ? tx2 : tx4;
      wdone[n] = which ? done2 : done4;
      if (n < 140 * div && wdone[n] === 1'b1) ndone++;
    end
  endtask

  task automatic decode(input int div);
    width_err = 0;
    frame_err = 0;
    for (int p = 0; p < 140; p++)
      for (int k = 1; k < div; k++)
        if (wtx[p*div+k] !== wtx[p*div]) width_err++;
    for (int b = 0; b < 14; b++) begin
      if (wtx[b*10*div] !== 1'b0) frame_err++;
      for (int i = 0; i < 8; i++) rx_bytes[b][i] = wtx[(b*10+1+i)*div];
      if (wtx[(b*10+9)*div] !== 1'b1) frame_err++;
    end
  endtask

  task automatic launch4(input logic [31:0] a, input logic [31:0] b, input logic [31:0] c);
    @(negedge clk);
    d1 = a; d2 = b; d3 = c;
    start4 = 1'b1;
    @(negedge clk);
    start4 = 1'b0;
  endtask

  task automatic test_reset;
    #12;
    checks++; if (tx4 !== 1'b1 || tx2 !== 1'b1) begin errors++; $display("FAIL reset_tx: got %b/%b want 1/1", tx4, tx2); end
    checks++; if (busy4 !== 1'b0 || done4 !== 1'b0) begin errors++; $display("FAIL reset_busy_done: got %b/%b want 0/0", busy4, done4); end
    checks++; if (cnt4 !== 16'h0 || cnt2 !== 16'h0) begin errors++; $display("FAIL reset_cnt: got %h/%h want 0000", cnt4, cnt2); end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_golden;
    int nd;
    launch4(32'h0000000C, 32'h000000FF, 32'h00B8A398);
    checks++; if (tx4 !== 1'b0 || busy4 !== 1'b1) begin errors++; $display("FAIL golden_accept: tx=%b busy=%b want 0/1", tx4, busy4); end
    record(1'b0, 4, nd);
    decode(4);
    for (int b = 0; b < 14; b++) begin
      checks++; if (rx_bytes[b] !== gold[b]) begin errors++; $display("FAIL golden_byte%0d: got %h want %h", b, rx_bytes[b], gold[b]); end
    end
    checks++; if (wdone[560] !== 1'b1 || nd !== 0) begin errors++; $display("FAIL golden_done_at_560: done=%b early=%0d want 1/0", wdone[560], nd); end
    checks++; if (busy4 !== 1'b0 || cnt4 !== 16'd1) begin errors++; $display("FAIL golden_end: busy=%b cnt=%0d want 0/1", busy4, cnt4); end
    @(negedge clk);
    checks++; if (done4 !== 1'b0) begin errors++; $display("FAIL golden_done_pulse: done=%b want 0", done4); end
  endtask

  task automatic test_bit_timing;
    int nd;
    int idle_bad = 0;
    repeat (5) begin
      @(negedge clk);
      if (tx4 !== 1'b1) idle_bad++;
    end
    checks++; if (idle_bad !== 0) begin errors++; $display("FAIL timing_pre_idle: %0d low cycles want 0", idle_bad); end
    launch4(32'h12345678, 32'hDEADBEEF, 32'h00000001);
    record(1'b0, 4, nd);
    decode(4);
    checks++; if (width_err !== 0) begin errors++; $display("FAIL timing_width: %0d bad samples want 0", width_err); end
    checks++; if (frame_err !== 0) begin errors++; $display("FAIL timing_framing: %0d bad start/stop want 0", frame_err); end
    for (int b = 0; b < 14; b++) begin
      checks++; if (rx_bytes[b] !== pat2[b]) begin errors++; $display("FAIL timing_byte%0d: got %h want %h", b, rx_bytes[b], pat2[b]); end
    end
    checks++; if (wtx[560] !== 1'b1 || wdone[560] !== 1'b1) begin errors++; $display("FAIL timing_end: tx=%b done=%b want 1/1", wtx[560], wdone[560]); end
    @(negedge clk);
    checks++; if (tx4 !== 1'b1 || cnt4 !== 16'd2) begin errors++; $display("FAIL timing_post: tx=%b cnt=%0d want 1/2", tx4, cnt4); end
  endtask

  task automatic test_snapshot_isolation;
    int nd;
    int extra = 0;
    int mism = 0;
    launch4(32'h0000000C, 32'h000000FF, 32'h00B8A398);
    fork
      record(1'b0, 4, nd);
      begin
        repeat (10) @(negedge clk);
        d1 = 32'hFFFFFFFF; d2 = 32'hFFFFFFFF; d3 = 32'hFFFFFFFF;
        repeat (30) @(negedge clk);
        start4 = 1'b1;
        @(negedge clk);
        start4 = 1'b0;
      end
    join
    decode(4);
    for (int b = 0; b < 14; b++) if (rx_bytes[b] !== gold[b]) mism++;
    checks++; if (mism !== 0) begin errors++; $display("FAIL iso_bytes: %0d bytes differ want 0", mism); end
    checks++; if (nd !== 0 || wdone[560] !== 1'b1) begin errors++; $display("FAIL iso_done: early=%0d end=%b want 0/1", nd, wdone[560]); end
    repeat (20) begin
      @(negedge clk);
      if (done4 === 1'b1 || busy4 === 1'b1) extra++;
    end
    checks++; if (extra !== 0) begin errors++; $display("FAIL iso_no_queue: %0d busy/done cycles want 0", extra); end
    checks++; if (cnt4 !== 16'd3) begin errors++; $display("FAIL iso_cnt: got %0d want 3", cnt4); end
  endtask

  task automatic test_back_to_back;
    int nd;
    int mism;
    @(negedge clk);
    d1 = 32'h0000000C; d2 = 32'h000000FF; d3 = 32'h00B8A398;
    start2 = 1'b1;
    @(negedge clk);
    for (int f = 0; f < 3; f++) begin
      record(1'b1, 2, nd);
      decode(2);
      mism = 0;
      for (int b = 0; b < 14; b++) if (rx_bytes[b] !== gold[b]) mism++;
      checks++; if (mism !== 0 || width_err !== 0 || frame_err !== 0) begin errors++; $display("FAIL b2b_frame%0d: mism=%0d width=%0d framing=%0d want 0/0/0", f, mism, width_err, frame_err); end
      checks++; if (wtx[280] !== 1'b1 || wdone[280] !== 1'b1 || nd !== 0) begin errors++; $display("FAIL b2b_gap%0d: tx=%b done=%b early=%0d want 1/1/0", f, wtx[280], wdone[280], nd); end
      if (f == 2) start2 = 1'b0;
      @(negedge clk);
      if (f < 2) begin
        checks++; if (tx2 !== 1'b0) begin errors++; $display("FAIL b2b_restart%0d: tx=%b want 0", f, tx2); end
      end
    end
    checks++; if (busy2 !== 1'b0 || tx2 !== 1'b1 || cnt2 !== 16'd3) begin errors++; $display("FAIL b2b_end: busy=%b tx=%b cnt=%0d want 0/1/3", busy2, tx2, cnt2); end
  endtask

  task automatic test_reset_mid_frame;
    int nd;
    int mism = 0;
    launch4(32'h0000000C, 32'h000000FF, 32'h00B8A398);
    repeat (200) @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++; if (tx4 !== 1'b1 || busy4 !== 1'b0 || done4 !== 1'b0) begin errors++; $display("FAIL rst_mid_outputs: tx=%b busy=%b done=%b want 1/0/0", tx4, busy4, done4); end
    checks++; if (cnt4 !== 16'd0) begin errors++; $display("FAIL rst_mid_cnt: got %0d want 0", cnt4); end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    launch4(32'h0000000C, 32'h000000FF, 32'h00B8A398);
    record(1'b0, 4, nd);
    decode(4);
    for (int b = 0; b < 14; b++) if (rx_bytes[b] !== gold[b]) mism++;
    checks++; if (mism !== 0 || frame_err !== 0) begin errors++; $display("FAIL rst_mid_refire: mism=%0d framing=%0d want 0/0", mism, frame_err); end
    checks++; if (wdone[560] !== 1'b1 || cnt4 !== 16'd1) begin errors++; $display("FAIL rst_mid_cnt_after: done=%b cnt=%0d want 1/1", wdone[560], cnt4); end
  endtask

  task automatic test_counter_wrap;
    int nd;
    @(negedge clk);
    force dut4.frame_cnt_q = 16'hFFFF;
    @(negedge clk);
    release dut4.frame_cnt_q;
    @(negedge clk);
    checks++; if (cnt4 !== 16'hFFFF) begin errors++; $display("FAIL wrap_deposit: got %h want ffff", cnt4); end
    launch4(32'h0000000C, 32'h000000FF, 32'h00B8A398);
    record(1'b0, 4, nd);
    checks++; if (cnt4 !== 16'h0000 || done4 !== 1'b1) begin errors++; $display("FAIL wrap_cnt: cnt=%h done=%b want 0000/1", cnt4, done4); end
  endtask

  initial begin
    test_reset();
    test_golden();
    test_bit_timing();
    test_snapshot_isolation();
    test_back_to_back();
    test_reset_mid_frame();
    test_counter_wrap();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

endmodule
